// File: rtl/ro_sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ro_sensor_pkg
// Description : Shared types and default widths for the ring-oscillator
//               sensor enable path.
// Revision    : 1.0 - initial release
// ============================================================================
package ro_sensor_pkg;

    localparam int c_cnt_w_default   = 16;
    localparam int c_burst_w_default = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } ro_state_t;

endpackage
`default_nettype wire

// File: rtl/ro_enable_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ro_enable_ctrl_if
// Description : Control/status bundle between a burst requester and the
//               ring-oscillator enable controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ro_enable_ctrl_if
    import ro_sensor_pkg::*;
#(
    parameter int CNT_W   = c_cnt_w_default,
    parameter int BURST_W = c_burst_w_default
);
    logic               start;
    logic               stop;
    logic [CNT_W-1:0]   on_cycles;
    logic [CNT_W-1:0]   off_cycles;
    logic [BURST_W-1:0] burst_count;
    logic               ro_en;
    logic               busy;
    logic               done;
    logic               aborted;
    logic               err;
    logic [BURST_W-1:0] periods_done;

    modport master (
        output start, stop, on_cycles, off_cycles, burst_count,
        input  ro_en, busy, done, aborted, err, periods_done
    );

    modport slave (
        input  start, stop, on_cycles, off_cycles, burst_count,
        output ro_en, busy, done, aborted, err, periods_done
    );
endinterface
`default_nettype wire

// File: rtl/ro_period_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ro_period_cnt
// Description : Loadable down-counter; tc flags the last cycle of a period.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_period_cnt #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    input  wire logic             dec,
    output logic                  tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // A period loaded with N ends on the cycle the count reads 1.
    assign tc = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/ro_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ro_enable_ctrl
// Description : Burst sequencer producing a registered ON/OFF enable for a
//               ring-oscillator bank.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_enable_ctrl
    import ro_sensor_pkg::*;
#(
    parameter int CNT_W   = c_cnt_w_default,
    parameter int BURST_W = c_burst_w_default
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ro_enable_ctrl_if.slave   bus
);

    ro_state_t          r_state;
    ro_state_t          w_next_state;
    logic [CNT_W-1:0]   r_on_len;
    logic [CNT_W-1:0]   r_off_len;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] r_periods_done;
    logic [BURST_W-1:0] w_pd_inc;
    logic               r_ro_en, r_busy, r_done, r_aborted, r_err;
    logic               w_start_ok, w_start_bad;
    logic               w_load, w_dec, w_tc, w_inc, w_abort;
    logic [CNT_W-1:0]   w_load_val;

    assign w_start_ok  = (r_state == ST_IDLE) && bus.start && !bus.stop && (bus.on_cycles != '0);
    assign w_start_bad = (r_state == ST_IDLE) && bus.start && !bus.stop && (bus.on_cycles == '0);
    assign w_pd_inc    = r_periods_done + BURST_W'(1);
    assign w_dec       = (r_state == ST_ON) || (r_state == ST_OFF);

    ro_period_cnt #(.CNT_W(CNT_W)) u_period_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .tc       (w_tc)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = r_on_len;
        w_inc        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_ON;
                    w_load       = 1'b1;
                    w_load_val   = bus.on_cycles;
                end
            end
            ST_ON: begin
                // stop outranks a coinciding period end, so that period is not counted
                if (bus.stop) begin
                    w_next_state = ST_DONE;
                    w_abort      = 1'b1;
                end else if (w_tc) begin
                    w_inc = 1'b1;
                    if ((r_burst != '0) && (w_pd_inc == r_burst)) begin
                        w_next_state = ST_DONE;
                    end else if (r_off_len == '0) begin
                        w_next_state = ST_ON;
                        w_load       = 1'b1;
                        w_load_val   = r_on_len;
                    end else begin
                        w_next_state = ST_OFF;
                        w_load       = 1'b1;
                        w_load_val   = r_off_len;
                    end
                end
            end
            ST_OFF: begin
                if (bus.stop) begin
                    w_next_state = ST_DONE;
                    w_abort      = 1'b1;
                end else if (w_tc) begin
                    w_next_state = ST_ON;
                    w_load       = 1'b1;
                    w_load_val   = r_on_len;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_on_len       <= '0;
            r_off_len      <= '0;
            r_burst        <= '0;
            r_periods_done <= '0;
            r_ro_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_aborted      <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start_ok) begin
                r_on_len       <= bus.on_cycles;
                r_off_len      <= bus.off_cycles;
                r_burst        <= bus.burst_count;
                r_periods_done <= '0;
            end else if (w_inc) begin
                r_periods_done <= w_pd_inc;
            end
            // Outputs are decoded from the next state so they align with the state register.
            r_ro_en   <= (w_next_state == ST_ON);
            r_busy    <= (w_next_state == ST_ON) || (w_next_state == ST_OFF);
            r_done    <= (w_next_state == ST_DONE);
            r_aborted <= w_abort;
            r_err     <= w_start_bad;
        end
    end

    assign bus.ro_en        = r_ro_en;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.aborted      = r_aborted;
    assign bus.err          = r_err;
    assign bus.periods_done = r_periods_done;

endmodule
`default_nettype wire
